// File: rtl/ori_video_pkg.sv
// Shared constants and types for the Orion video fetch/shift path.
package ori_video_pkg;

  localparam int unsigned VIS_COLS_DEF = 48;
  localparam int unsigned VIS_ROWS_DEF = 256;

  localparam logic [1:0] MODE_MONO = 2'd0;
  localparam logic [1:0] MODE_4C   = 2'd1;
  localparam logic [1:0] MODE_16C  = 2'd2;
  localparam logic [1:0] MODE_OFF  = 2'd3;

  // {i,r,g,b}
  localparam logic [3:0] IRGB_BLACK = 4'b0000;
  localparam logic [3:0] IRGB_RED   = 4'b0100;
  localparam logic [3:0] IRGB_GREEN = 4'b0010;
  localparam logic [3:0] IRGB_BLUE  = 4'b0001;

  typedef enum logic {
    TAIL   = 1'b0,
    ACTIVE = 1'b1
  } phase_e;

endpackage

// File: rtl/ori_pix_decode.sv
// Combinational decode of the current plane/colour bits into an IRGB pixel.
module ori_pix_decode
  import ori_video_pkg::*;
(
  input  logic [1:0] i_mode,
  input  logic       i_plane_bit,
  input  logic       i_color_bit,
  input  logic [7:0] i_attr,
  output logic [3:0] o_irgb
);

  // Mode-dependent pixel colour selection.
  always_comb begin
    o_irgb = IRGB_BLACK;
    case (i_mode)
      MODE_MONO: o_irgb = i_plane_bit ? IRGB_GREEN : IRGB_BLACK;
      MODE_4C: begin
        case ({i_plane_bit, i_color_bit})
          2'b01:   o_irgb = IRGB_RED;
          2'b10:   o_irgb = IRGB_GREEN;
          2'b11:   o_irgb = IRGB_BLUE;
          default: o_irgb = IRGB_BLACK;
        endcase
      end
      MODE_16C: o_irgb = i_plane_bit ? i_attr[7:4] : i_attr[3:0];
      default:  o_irgb = IRGB_BLACK;
    endcase
  end

endmodule

// File: rtl/ori_video_fetch_shifter.sv
// Fetches one pixel/colour byte pair per visible column and serialises it MSB first.
module ori_video_fetch_shifter
  import ori_video_pkg::*;
#(
  parameter int unsigned VIS_COLS = VIS_COLS_DEF,
  parameter int unsigned VIS_ROWS = VIS_ROWS_DEF
) (
  input  logic        clk_i,
  input  logic        por_i,
  input  logic        cke_10m_i,
  input  logic        hor_inc_i,
  input  logic [5:0]  cnt_hor_i,
  input  logic [8:0]  cnt_vert_i,
  input  logic [1:0]  video_page_i,
  input  logic [1:0]  color_mode_i,
  output logic        vid_req_o,
  output logic [15:0] vid_addr_o,
  input  logic        vid_ack_i,
  input  logic [7:0]  vid_data_i,
  input  logic [7:0]  vid_color_i,
  output logic [3:0]  pix_o,
  output logic        de_o,
  output logic        underrun_o
);

  phase_e      r_phase, w_phase_d;
  logic [5:0]  r_prev_hor;
  logic        r_fetch_pend;
  logic        r_req;
  logic [15:0] r_addr;
  logic [7:0]  r_hold_pix, r_hold_col;
  logic        r_hold_valid;
  logic [7:0]  r_sh_pix, r_sh_col, r_attr;
  logic [1:0]  r_mode;
  logic        r_de_byte;
  logic [3:0]  r_pix;
  logic        r_de;
  logic        r_underrun;

  logic        w_load, w_fetch, w_visible;
  logic [3:0]  w_irgb;

  assign w_load    = cke_10m_i & hor_inc_i;
  assign w_fetch   = cke_10m_i & r_fetch_pend;
  // Phase used here is the one already updated for this cke cycle's counter value.
  assign w_visible = (w_phase_d == ACTIVE) && (32'(cnt_hor_i) < VIS_COLS) &&
                     (32'(cnt_vert_i) < VIS_ROWS);

  // Line phase: 63->0 enters the tail, 15->0 or any column >=16 means active.
  always_comb begin
    w_phase_d = r_phase;
    if (cke_10m_i) begin
      if (cnt_hor_i >= 6'd16) begin
        w_phase_d = ACTIVE;
      end else if (cnt_hor_i == 6'd0 && r_prev_hor == 6'd63) begin
        w_phase_d = TAIL;
      end else if (cnt_hor_i == 6'd0 && r_prev_hor == 6'd15) begin
        w_phase_d = ACTIVE;
      end
    end
  end

  // Phase tracker state.
  always_ff @(posedge clk_i) begin
    if (por_i) begin
      r_phase    <= TAIL;
      r_prev_hor <= '0;
    end else begin
      r_phase <= w_phase_d;
      if (cke_10m_i) r_prev_hor <= cnt_hor_i;
    end
  end

  // Fetch request/ack handling and holding registers.
  always_ff @(posedge clk_i) begin
    if (por_i) begin
      r_fetch_pend <= 1'b0;
      r_req        <= 1'b0;
      r_addr       <= '0;
      r_hold_pix   <= '0;
      r_hold_col   <= '0;
      r_hold_valid <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_underrun <= 1'b0;
      if (w_load) begin
        // An ack coinciding with the load point is too late and is dropped.
        r_fetch_pend <= 1'b1;
        r_hold_valid <= 1'b0;
        if (r_req) begin
          r_req      <= 1'b0;
          r_underrun <= 1'b1;
        end
      end else begin
        if (w_fetch) r_fetch_pend <= 1'b0;
        if (r_req && vid_ack_i) begin
          r_hold_pix   <= vid_data_i;
          r_hold_col   <= vid_color_i;
          r_hold_valid <= 1'b1;
          r_req        <= 1'b0;
        end else if (w_fetch && w_visible) begin
          r_req  <= 1'b1;
          r_addr <= {~video_page_i, cnt_hor_i, cnt_vert_i[7:0]};
        end
      end
    end
  end

  // Shift register, per-byte mode latch and registered pixel output.
  always_ff @(posedge clk_i) begin
    if (por_i) begin
      r_sh_pix  <= '0;
      r_sh_col  <= '0;
      r_attr    <= '0;
      r_mode    <= MODE_MONO;
      r_de_byte <= 1'b0;
      r_pix     <= '0;
      r_de      <= 1'b0;
    end else if (cke_10m_i) begin
      r_pix <= r_de_byte ? w_irgb : IRGB_BLACK;
      r_de  <= r_de_byte;
      if (w_load) begin
        r_mode <= color_mode_i;
        if (r_req) begin
          // Missed fetch: show a blank but enabled byte.
          r_sh_pix  <= '0;
          r_sh_col  <= '0;
          r_attr    <= '0;
          r_de_byte <= 1'b1;
        end else begin
          r_sh_pix  <= r_hold_pix;
          r_sh_col  <= r_hold_col;
          r_attr    <= r_hold_col;
          r_de_byte <= r_hold_valid;
        end
      end else begin
        r_sh_pix <= {r_sh_pix[6:0], 1'b0};
        r_sh_col <= {r_sh_col[6:0], 1'b0};
      end
    end
  end

  ori_pix_decode u_pix_decode (
    .i_mode      (r_mode),
    .i_plane_bit (r_sh_pix[7]),
    .i_color_bit (r_sh_col[7]),
    .i_attr      (r_attr),
    .o_irgb      (w_irgb)
  );

  assign vid_req_o  = r_req;
  assign vid_addr_o = r_addr;
  assign pix_o      = r_pix;
  assign de_o       = r_de;
  assign underrun_o = r_underrun;

endmodule

// File: tb/tb_ori_video_fetch_shifter.sv
// Directed self-checking bench for ori_video_fetch_shifter.
module tb_ori_video_fetch_shifter;

  logic        clk_i = 1'b0;
  logic        por_i;
  logic        cke_10m_i;
  logic        hor_inc_i;
  logic [5:0]  cnt_hor_i;
  logic [8:0]  cnt_vert_i;
  logic [1:0]  video_page_i;
  logic [1:0]  color_mode_i;
  logic        vid_req_o;
  logic [15:0] vid_addr_o;
  logic        vid_ack_i;
  logic [7:0]  vid_data_i;
  logic [7:0]  vid_color_i;
  logic [3:0]  pix_o;
  logic        de_o;
  logic        underrun_o;

  always #5 clk_i = ~clk_i;

  ori_video_fetch_shifter dut (
    .clk_i        (clk_i),
    .por_i        (por_i),
    .cke_10m_i    (cke_10m_i),
    .hor_inc_i    (hor_inc_i),
    .cnt_hor_i    (cnt_hor_i),
    .cnt_vert_i   (cnt_vert_i),
    .video_page_i (video_page_i),
    .color_mode_i (color_mode_i),
    .vid_req_o    (vid_req_o),
    .vid_addr_o   (vid_addr_o),
    .vid_ack_i    (vid_ack_i),
    .vid_data_i   (vid_data_i),
    .vid_color_i  (vid_color_i),
    .pix_o        (pix_o),
    .de_o         (de_o),
    .underrun_o   (underrun_o)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Output log, one entry sampled just after each cke edge.
  logic [3:0]  pix_log  [0:2047];
  logic        de_log   [0:2047];
  logic        req_log  [0:2047];
  logic        und_log  [0:2047];
  logic [15:0] addr_log [0:2047];
  int          cke_n = 0;

  // Memory responder: ack ack_delay clocks after req rises (<=0 never acks).
  int          req_age   = 0;
  int          ack_delay = -1;
  logic        force_ack = 1'b0;
  logic [7:0]  ack_data  = 8'h00;
  logic [7:0]  ack_color = 8'h00;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk_step();
    vid_ack_i   = 1'b0;
    vid_data_i  = ack_data;
    vid_color_i = ack_color;
    if (vid_req_o) req_age++;
    else req_age = 0;
    if (ack_delay > 0 && req_age == ack_delay) vid_ack_i = 1'b1;
    if (force_ack) begin
      vid_ack_i = 1'b1;
      force_ack = 1'b0;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic cke_cycle(input logic hi, input logic [5:0] c);
    cke_10m_i = 1'b1;
    hor_inc_i = hi;
    cnt_hor_i = c;
    clk_step();
    pix_log[cke_n]  = pix_o;
    de_log[cke_n]   = de_o;
    req_log[cke_n]  = vid_req_o;
    und_log[cke_n]  = underrun_o;
    addr_log[cke_n] = vid_addr_o;
    cke_n++;
    cke_10m_i = 1'b0;
    hor_inc_i = 1'b0;
    clk_step();
  endtask

  // One byte period: load point then 7 more pixel enables; optional mode change after load.
  task automatic byte_period(input logic [5:0] c, input int new_mode, output int l);
    l = cke_n;
    cke_cycle(1'b1, c);
    if (new_mode >= 0) color_mode_i = 2'(new_mode);
    for (int k = 0; k < 7; k++) cke_cycle(1'b0, c);
  endtask

  // Eight pixels of the byte loaded at log index l (first pixel in the top nibble).
  task automatic chk_byte(input string tag, input int l, input logic [31:0] exp);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s pix%0d", tag, k), 16'(pix_log[l + 1 + k]), 16'(exp[31 - 4*k -: 4]));
      chk($sformatf("%s de%0d", tag, k), 16'(de_log[l + 1 + k]), 16'd1);
    end
  endtask

  int  l0, l1, l2, l3;
  logic any_req;

  initial begin
    por_i        = 1'b1;
    cke_10m_i    = 1'b0;
    hor_inc_i    = 1'b0;
    cnt_hor_i    = 6'd0;
    cnt_vert_i   = 9'd0;
    video_page_i = 2'd0;
    color_mode_i = 2'd0;
    vid_ack_i    = 1'b0;
    vid_data_i   = 8'h00;
    vid_color_i  = 8'h00;

    // Reset state
    repeat (3) clk_step();
    chk("rst pix", 16'(pix_o), 16'd0);
    chk("rst de", 16'(de_o), 16'd0);
    chk("rst req", 16'(vid_req_o), 16'd0);
    chk("rst addr", vid_addr_o, 16'h0000);
    chk("rst und", 16'(underrun_o), 16'd0);
    por_i = 1'b0;
    clk_step();

    // Resynchronise phase on an invisible line, then mono byte at column 0
    cnt_vert_i = 9'd300;
    byte_period(6'd20, -1, l0);
    cnt_vert_i = 9'd0;
    ack_delay  = 2;
    ack_data   = 8'hA5;
    ack_color  = 8'h00;
    byte_period(6'd0, -1, l0);
    chk("mono req", 16'(req_log[l0 + 1]), 16'd1);
    chk("mono addr", addr_log[l0 + 1], 16'hC000);
    byte_period(6'd48, -1, l1);
    byte_period(6'd49, -1, l2);
    chk_byte("mono", l1, 32'h2020_0202);
    chk("mono de before", 16'(de_log[l1]), 16'd0);
    chk("mono de after", 16'(de_log[l1 + 9]), 16'd0);

    // Sixteen-colour byte; mode switched to mono mid-byte must not take effect
    ack_data     = 8'hF0;
    ack_color    = 8'h4E;
    color_mode_i = 2'd2;
    byte_period(6'd1, -1, l0);
    chk("16c addr", addr_log[l0 + 1], 16'hC100);
    byte_period(6'd48, 0, l1);
    byte_period(6'd49, -1, l2);
    chk_byte("16c", l1, 32'h4444_EEEE);

    // Four-colour byte
    ack_data     = 8'hCA;
    ack_color    = 8'hA6;
    color_mode_i = 2'd1;
    byte_period(6'd2, -1, l0);
    byte_period(6'd48, -1, l1);
    byte_period(6'd49, -1, l2);
    chk_byte("4c", l1, 32'h1240_2410);

    // Addressing corners
    video_page_i = 2'd2;
    cnt_vert_i   = 9'd255;
    byte_period(6'd47, -1, l0);
    chk("addr req", 16'(req_log[l0 + 1]), 16'd1);
    chk("addr value", addr_log[l0 + 1], 16'h6FFF);
    cnt_vert_i = 9'd256;
    byte_period(6'd5, -1, l0);
    chk("row256 req", 16'(req_log[l0 + 1]), 16'd0);
    cnt_vert_i = 9'd255;
    byte_period(6'd48, -1, l0);
    chk("col48 req", 16'(req_log[l0 + 1]), 16'd0);

    // Line tail: 63, 0..15 are tail, second 0 is active
    video_page_i = 2'd0;
    cnt_vert_i   = 9'd0;
    byte_period(6'd63, -1, l0);
    any_req = 1'b0;
    for (int c = 0; c < 16; c++) begin
      byte_period(6'(c), -1, l0);
      for (int k = 0; k < 8; k++) any_req = any_req | req_log[l0 + k];
    end
    chk("tail no req", 16'(any_req), 16'd0);
    byte_period(6'd0, -1, l0);
    chk("tail exit req", 16'(req_log[l0 + 1]), 16'd1);
    chk("tail exit addr", addr_log[l0 + 1], 16'hC000);

    // Late ack: underrun, blank enabled byte, later ack ignored
    ack_delay    = -1;
    color_mode_i = 2'd0;
    byte_period(6'd1, -1, l0);
    chk("late req held", 16'(req_log[l0 + 7]), 16'd1);
    l1 = cke_n;
    cke_cycle(1'b1, 6'd48);
    chk("late und", 16'(und_log[l1]), 16'd1);
    chk("late req drop", 16'(req_log[l1]), 16'd0);
    ack_data  = 8'hFF;
    ack_color = 8'hFF;
    force_ack = 1'b1;
    for (int k = 0; k < 7; k++) cke_cycle(1'b0, 6'd48);
    chk("late und pulse", 16'(und_log[l1 + 1]), 16'd0);
    byte_period(6'd49, -1, l2);
    byte_period(6'd50, -1, l3);
    chk_byte("late", l1, 32'h0000_0000);
    chk("late ack ignored de", 16'(de_log[l2 + 1]), 16'd0);

    // Reset while a request is outstanding
    l0 = cke_n;
    cke_cycle(1'b1, 6'd3);
    cke_cycle(1'b0, 6'd3);
    chk("rst2 pre req", 16'(req_log[l0 + 1]), 16'd1);
    por_i = 1'b1;
    clk_step();
    chk("rst2 req", 16'(vid_req_o), 16'd0);
    chk("rst2 pix", 16'(pix_o), 16'd0);
    chk("rst2 de", 16'(de_o), 16'd0);
    chk("rst2 addr", vid_addr_o, 16'h0000);
    chk("rst2 und", 16'(underrun_o), 16'd0);
    por_i     = 1'b0;
    force_ack = 1'b1;
    clk_step();
    ack_delay = 2;
    ack_data  = 8'hA5;
    any_req   = 1'b0;
    byte_period(6'd0, -1, l0);
    byte_period(6'd1, -1, l1);
    byte_period(6'd50, -1, l2);
    for (int k = 0; k < 24; k++) any_req = any_req | req_log[l0 + k];
    chk("rst2 no early req", 16'(any_req), 16'd0);
    chk("rst2 ack ignored de", 16'(de_log[l0 + 1]), 16'd0);
    byte_period(6'd0, -1, l3);
    chk("rst2 first req", 16'(req_log[l3 + 1]), 16'd1);
    chk("rst2 first addr", addr_log[l3 + 1], 16'hC000);
    byte_period(6'd48, -1, l0);
    byte_period(6'd49, -1, l1);
    chk_byte("rst2 mono", l0, 32'h2020_0202);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ori_video_fetch_shifter.md
Name: ori_video_fetch_shifter

Overview:
Downstream consumer of the Orion horizontal/vertical timing generator. For each visible byte column, it fetches one pixel-plane byte and one colour-plane byte from video RAM through a request/acknowledge port. It then serialises the column into 8 pixels, MSB first, on the 10 MHz pixel enable. It outputs 4-bit IRGB pixels plus a display-enable signal aligned to them, one byte period behind the counters.

Parameters:
VIS_COLS, 48, number of visible byte columns per line (384/8)
VIS_ROWS, 256, number of visible lines

Ports:
clk_i  in  1  system clock
por_i  in  1  reset, synchronous, active-high
cke_10m_i  in  1  pixel clock enable, one clk_i cycle per pixel
hor_inc_i  in  1  byte strobe from the timing generator; valid only with cke_10m_i, once per 8 cke cycles
cnt_hor_i  in  6  timing generator byte counter
cnt_vert_i  in  9  timing generator line counter
video_page_i  in  2  screen page select
color_mode_i  in  2  0 mono, 1 four-colour, 2 sixteen-colour, 3 screen off
vid_req_o  out  1  fetch request, level
vid_addr_o  out  16  fetch address
vid_ack_i  in  1  one-clk_i pulse; data valid in the same cycle
vid_data_i  in  8  pixel-plane byte
vid_color_i  in  8  colour-plane byte, same address, second bank
pix_o  out  4  {i,r,g,b}
de_o  out  1  display enable aligned with pix_o
underrun_o  out  1  one-clk pulse when a fetch missed its load point

Behaviour:
- Reset is synchronous: with por_i high at a clk_i edge, all state clears, independent of cke_10m_i. After reset: pix_o=0, de_o=0, vid_req_o=0, vid_addr_o=0, underrun_o=0, phase=TAIL, holding registers=0, hold_valid=0.
- Phase tracker (updated in cke_10m_i cycles only, from the previous and current cnt_hor_i):
  - 63→0 sets TAIL.
  - 15→0 sets ACTIVE.
  - Any value ≥16 forces ACTIVE, so the tracker resynchronises within one line after reset.
- Load point: the cke_10m_i cycle in which hor_inc_i is high.
- Fetch point: the cke cycle immediately after a load point.
- Visibility at the fetch point: column c=cnt_hor_i is visible when phase=ACTIVE, c<VIS_COLS and cnt_vert_i<VIS_ROWS.
- Fetch for a visible column:
  - vid_req_o=1 next clk.
  - vid_addr_o = {~video_page_i, c[5:0], cnt_vert_i[7:0]}.
  - vid_addr_o is held stable while vid_req_o=1.
- Fetch completion:
  - vid_ack_i while vid_req_o=1 latches vid_data_i and vid_color_i into the holding registers, sets hold_valid and drops vid_req_o next clk.
  - vid_ack_i while vid_req_o=0 is ignored.
- Load point behaviour:
  - The shift register loads the holding registers, and color_mode_i is latched for the byte.
  - de_o is set to the load-time value of hold_valid, then hold_valid clears.
  - If vid_req_o is still high at the load point: load zeros, de_o=1, pulse underrun_o, drop vid_req_o. A vid_ack_i coincident with the load point counts as late and is discarded.
- Shift register: shifts left by 1 in every non-load cke cycle; the output pixel is bit 7. Latency: column c appears 8 pixel periods after its fetch point.
- Pixel decode (p = plane bit 7, a = latched colour byte, a_s = colour shift bit 7):
  - Mode 0: p ? 4'b0010 : 0.
  - Mode 1: {p, a_s}: 00→0000, 01→0100, 10→0010, 11→0001. The colour register shifts along with the plane register.
  - Mode 2: p ? a[7:4] : a[3:0]. The attribute byte is held for the byte period, not shifted.
  - Mode 3: 0.
- pix_o is forced to 0 whenever de_o=0. pix_o and de_o are registered and change only in cke cycles.
- A mode change takes effect at the next load point, never mid-byte.
- Reset mid-request: vid_req_o=0 on the next clk edge; a later ack is ignored.

Decomposition:
- Package ori_video_pkg holds:
  - Mode constants: MODE_MONO, MODE_4C, MODE_16C, MODE_OFF.
  - IRGB colour constants.
  - VIS_COLS and VIS_ROWS defaults.
  - Phase encoding: TAIL, ACTIVE.
- One sub-module, ori_pix_decode: purely combinational mode/bit → IRGB decode, instantiated once.

Test Plan:
- Mono: mode 0, page 0, line 0, column 0, ack 2 clk after req with data 0xA5:
  - Required: vid_addr_o=0xC000.
  - Required: 8 pixels after the next load point are 2,0,2,0,0,2,0,2.
  - Required: de_o=1 for exactly 8 cke cycles.
- Sixteen-colour: mode 2, data 0xF0, colour 0x4E → pixels 4,4,4,4,E,E,E,E.
- Addressing: page 2, line 255, column 47 → vid_addr_o=0x6FFF. Column 48 or line 256 → no request.
- Line tail: cnt_hor_i sequence 63,0..15,0 → no vid_req_o during 0..15 (TAIL); a request appears at the second 0 (ACTIVE).
- Late ack: no ack before the load point → underrun_o pulse, 8 pixels of 0 with de_o=1, vid_req_o low; an ack arriving later is ignored.
- Reset while vid_req_o=1 → all outputs 0 on the next clk; the first request after reset appears only at column 0 of a line following a cnt_hor_i≥16.
